// File: rtl/ahb_lite_mem_fifo_bridge.sv
// AHB-Lite slave to memory-controller FIFO bridge: commands, write data out, read data in.
// Latency: writes zero-wait when FIFOs have room; reads at least 2 wait states.
// Backpressure: CFIFO/WFIFO full and RFIFO empty stretch the data phase via HREADYOUT.
//
// Ports:
//   HCLK, HRESET                  clock (rising edge) / async active-high reset
//   HADDR..HREADY                 AHB-Lite slave inputs
//   HRDATA, HREADYOUT, HRESP      AHB-Lite slave outputs (HRDATA registered)
//   CFIFO_*                       command push {wr, be[3:0], addr[ADDR_WIDTH-1:0]}
//   WFIFO_*                       write-data push
//   RFIFO_*                       read-data pop (show-ahead FIFO)
// Optional feature macro: AHB_MEM_FIFO_ERR_EN enables HSIZE>2 errors, read
// timeout and discarding of late read data. Without it HRESP is tied low.
module ahb_lite_mem_fifo_bridge #(
    parameter int ADDR_WIDTH   = 26,
    parameter int READ_TIMEOUT = 255,
    parameter int CMD_WIDTH    = ADDR_WIDTH + 5
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [31:0]           HADDR,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HSEL,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  CFIFO_WEN,
    output logic [CMD_WIDTH-1:0]  CFIFO_WDATA,
    input  logic                  CFIFO_WFULL,
    output logic                  WFIFO_WEN,
    output logic [31:0]           WFIFO_WDATA,
    input  logic                  WFIFO_WFULL,
    output logic                  RFIFO_REN,
    input  logic [31:0]           RFIFO_RDATA,
    input  logic                  RFIFO_REMPTY
);

    typedef enum logic [2:0] {
        IDLE, WRITE, RD_CMD, RD_WAIT, RD_DONE, ERR1, ERR2
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic [3:0]              be_q;
    logic [3:0]              be_nxt;
    logic [31:0]             hrdata_q;
    logic                    accept;
    logic                    take_addr;
    logic                    rd_take;
    logic                    data_ok;
    logic                    size_err;
    logic                    timeout;
    logic                    unused_bits;

    assign accept  = HSEL & HREADY & HTRANS[1];
    assign rd_take = (state == RD_WAIT) & ~RFIFO_REMPTY & data_ok;

    // Upper address bits and HTRANS[0] are intentionally ignored.
    assign unused_bits = ^{HADDR, HTRANS[0], 32'(READ_TIMEOUT)};

    always_comb begin
        be_nxt = 4'b1111;
        case (HSIZE)
            3'd0:    be_nxt = 4'b0001 << HADDR[1:0];
            3'd1:    be_nxt = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_nxt = 4'b1111;
        endcase
    end

`ifdef AHB_MEM_FIFO_ERR_EN
    localparam int TO_W = (READ_TIMEOUT < 1) ? 1 : $clog2(READ_TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt;
    logic [3:0]      discard_cnt;
    logic            discard_pop;

    assign size_err    = (HSIZE > 3'd2);
    // Reads that timed out may still deliver data later; drop it in any state.
    assign discard_pop = (discard_cnt != 4'd0) & ~RFIFO_REMPTY;
    // A new read must not take data while stale words are still owed.
    assign data_ok     = (discard_cnt == 4'd0);
    assign timeout     = (state == RD_WAIT) & ~rd_take & (wait_cnt == TO_W'(READ_TIMEOUT));
    assign HRESP       = (state == ERR1) | (state == ERR2);
    assign RFIFO_REN   = rd_take | discard_pop;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wait_cnt    <= '0;
            discard_cnt <= 4'd0;
        end else begin
            wait_cnt <= (state == RD_WAIT) ? wait_cnt + TO_W'(1) : '0;
            // Simultaneous timeout and discard pop cancel out.
            case ({timeout, discard_pop})
                2'b10: if (discard_cnt != 4'hF) discard_cnt <= discard_cnt + 4'd1;
                2'b01: discard_cnt <= discard_cnt - 4'd1;
                default: discard_cnt <= discard_cnt;
            endcase
        end
    end
`else
    assign size_err  = 1'b0;
    assign data_ok   = 1'b1;
    assign timeout   = 1'b0;
    assign HRESP     = 1'b0;
    assign RFIFO_REN = rd_take;
`endif

    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        CFIFO_WEN = 1'b0;
        WFIFO_WEN = 1'b0;
        take_addr = 1'b0;
        case (state)
            IDLE: take_addr = accept;
            WRITE: begin
                // Command and data go out together so the back end sees them paired.
                if (!CFIFO_WFULL && !WFIFO_WFULL) begin
                    CFIFO_WEN = 1'b1;
                    WFIFO_WEN = 1'b1;
                    take_addr = accept;
                    state_nxt = IDLE;
                end else begin
                    HREADYOUT = 1'b0;
                end
            end
            RD_CMD: begin
                HREADYOUT = 1'b0;
                if (!CFIFO_WFULL) begin
                    CFIFO_WEN = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                HREADYOUT = 1'b0;
                if (rd_take)      state_nxt = RD_DONE;
                else if (timeout) state_nxt = ERR1;
            end
            RD_DONE: begin
                take_addr = accept;
                state_nxt = IDLE;
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                state_nxt = ERR2;
            end
            // Master cancels its next transfer on ERROR, so nothing is taken here.
            ERR2:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (take_addr) begin
            if (size_err)    state_nxt = ERR1;
            else if (HWRITE) state_nxt = WRITE;
            else             state_nxt = RD_CMD;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            be_q     <= 4'd0;
            hrdata_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (take_addr) begin
                addr_q <= HADDR[ADDR_WIDTH-1:0];
                wr_q   <= HWRITE;
                be_q   <= be_nxt;
            end
            if (rd_take) hrdata_q <= RFIFO_RDATA;
        end
    end

    assign HRDATA      = hrdata_q;
    assign CFIFO_WDATA = {wr_q, be_q, addr_q};
    assign WFIFO_WDATA = HWDATA;

endmodule

// File: tb/tb_ahb_lite_mem_fifo_bridge.sv
// Directed bench for ahb_lite_mem_fifo_bridge with command/write-data scoreboards
// and a show-ahead read FIFO model.
module tb_ahb_lite_mem_fifo_bridge;

    localparam int AW = 26;
    localparam int CW = AW + 5;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [31:0]   HADDR;
    logic [2:0]    HSIZE;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HSEL;
    logic          HREADY;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic          CFIFO_WEN;
    logic [CW-1:0] CFIFO_WDATA;
    logic          CFIFO_WFULL;
    logic          WFIFO_WEN;
    logic [31:0]   WFIFO_WDATA;
    logic          WFIFO_WFULL;
    logic          RFIFO_REN;
    logic [31:0]   RFIFO_RDATA;
    logic          RFIFO_REMPTY;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_lite_mem_fifo_bridge #(.ADDR_WIDTH(AW), .READ_TIMEOUT(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HSEL(HSEL),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .CFIFO_WEN(CFIFO_WEN), .CFIFO_WDATA(CFIFO_WDATA), .CFIFO_WFULL(CFIFO_WFULL),
        .WFIFO_WEN(WFIFO_WEN), .WFIFO_WDATA(WFIFO_WDATA), .WFIFO_WFULL(WFIFO_WFULL),
        .RFIFO_REN(RFIFO_REN), .RFIFO_RDATA(RFIFO_RDATA), .RFIFO_REMPTY(RFIFO_REMPTY)
    );

    int vectors = 0;
    int miscompares = 0;
    int cf_pushes = 0, wf_pushes = 0, ren_cnt = 0, stall_cnt = 0, resp_cnt = 0;
    int c0, w0, r0, s0, e0;

    logic [CW-1:0] cmd_exp[$];
    logic [31:0]   wd_exp[$];
    logic [31:0]   rq[$];
    logic [31:0]   junk;
    bit            pop_pend = 1'b0;

    logic [31:0] x_addr[8];
    logic        x_wr[8];
    logic [2:0]  x_sz[8];
    logic [31:0] x_wd[8];
    logic [31:0] x_rd[8];
    logic        x_err[8];
    logic        x_push[8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] be_of(input logic [2:0] sz, input logic [31:0] a);
        logic [3:0] b;
        b = 4'b1111;
        if (sz == 3'd0) begin
            case (a[1:0])
                2'd0: b = 4'b0001;
                2'd1: b = 4'b0010;
                2'd2: b = 4'b0100;
                default: b = 4'b1000;
            endcase
        end else if (sz == 3'd1) begin
            b = a[1] ? 4'b1100 : 4'b0011;
        end
        return b;
    endfunction

    task automatic set_x(input int i, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [31:0] rd, input logic err, input logic push);
        x_addr[i] = a; x_wr[i] = wr; x_sz[i] = sz; x_wd[i] = wd;
        x_rd[i] = rd; x_err[i] = err; x_push[i] = push;
    endtask

    task automatic snap();
        c0 = cf_pushes; w0 = wf_pushes; r0 = ren_cnt; s0 = stall_cnt; e0 = resp_cnt;
    endtask

    // Pipelined AHB master: address phase i overlaps data phase i-1.
    task automatic run(input int n);
        bit rdy;
        int guard;
        for (int i = 0; i < n; i++) begin
            if (x_push[i]) begin
                cmd_exp.push_back({x_wr[i], be_of(x_sz[i], x_addr[i]), x_addr[i][AW-1:0]});
                if (x_wr[i]) wd_exp.push_back(x_wd[i]);
            end
        end
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                HSEL = 1'b1; HTRANS = 2'b10; HADDR = x_addr[i];
                HWRITE = x_wr[i]; HSIZE = x_sz[i];
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
            end
            if (i > 0) HWDATA = x_wd[i-1];
            guard = 0;
            do begin
                @(negedge HCLK);
                rdy = HREADYOUT;
                if (rdy && i > 0) begin
                    chk("hresp", HRESP, x_err[i-1]);
                    if (!x_wr[i-1] && !x_err[i-1]) chk("hrdata", HRDATA, x_rd[i-1]);
                end
                guard++;
                @(posedge HCLK); #1;
            end while (!rdy && guard < 100);
            if (!rdy) chk("hready_timeout", rdy, 1'b1);
        end
    endtask

    // Monitor: scoreboard pops and activity counters, sampled mid-cycle.
    always @(negedge HCLK) begin
        if (!HRESET) begin
            if (CFIFO_WEN) begin
                cf_pushes++;
                chk("cfifo_push_when_full", CFIFO_WFULL, 1'b0);
                chk("cfifo_wdata", CFIFO_WDATA, (cmd_exp.size() > 0) ? cmd_exp.pop_front() : 'x);
            end
            if (WFIFO_WEN) begin
                wf_pushes++;
                chk("wfifo_push_when_full", WFIFO_WFULL, 1'b0);
                chk("wfifo_wdata", WFIFO_WDATA, (wd_exp.size() > 0) ? wd_exp.pop_front() : 'x);
            end
            if (RFIFO_REN) begin
                ren_cnt++;
                chk("rfifo_pop_when_empty", RFIFO_REMPTY, 1'b0);
                pop_pend = 1'b1;
            end
            if (!HREADYOUT) stall_cnt++;
            if (HRESP) resp_cnt++;
        end
    end

    // Show-ahead read FIFO model, updated just after each rising edge.
    always @(posedge HCLK) begin
        #2;
        if (pop_pend) begin
            if (rq.size() > 0) junk = rq.pop_front();
            pop_pend = 1'b0;
        end
        RFIFO_REMPTY = (rq.size() == 0);
        RFIFO_RDATA  = (rq.size() > 0) ? rq[0] : 32'h0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; HADDR = 0; HSIZE = 0; HTRANS = 0; HWRITE = 0; HWDATA = 0; HSEL = 0;
        CFIFO_WFULL = 0; WFIFO_WFULL = 0; RFIFO_REMPTY = 1'b1; RFIFO_RDATA = 0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_hresp", HRESP, 1'b0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_cfifo_wen", CFIFO_WEN, 1'b0);
        chk("rst_wfifo_wen", WFIFO_WEN, 1'b0);
        chk("rst_rfifo_ren", RFIFO_REN, 1'b0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        // Byte write to 0x3, zero wait.
        snap();
        set_x(0, 32'h0000_0003, 1, 3'd0, 32'hAA00_0000, 0, 0, 1);
        run(1);
        chk("bytewr_stalls", stall_cnt - s0, 0);
        chk("bytewr_cpush", cf_pushes - c0, 1);
        chk("bytewr_wpush", wf_pushes - w0, 1);

        // Sub-word enables and address truncation, back to back.
        snap();
        set_x(0, 32'h0000_0002, 1, 3'd1, 32'h1111_2222, 0, 0, 1);
        set_x(1, 32'h0000_0010, 1, 3'd1, 32'h3333_4444, 0, 0, 1);
        set_x(2, 32'h0000_0021, 1, 3'd0, 32'h0000_5500, 0, 0, 1);
        set_x(3, 32'hFC00_0104, 1, 3'd2, 32'h6666_7777, 0, 0, 1);
        run(4);
        chk("subword_stalls", stall_cnt - s0, 0);
        chk("subword_cpush", cf_pushes - c0, 4);

        // Four word writes, WFIFO full for 3 cycles during the second.
        snap();
        for (int i = 0; i < 4; i++) set_x(i, 32'h0000_1000 + 32'(i * 4), 1, 3'd2, 32'hA5A5_0000 + 32'(i), 0, 0, 1);
        fork
            run(4);
            begin
                repeat (2) @(posedge HCLK);
                #1 WFIFO_WFULL = 1'b1;
                repeat (3) @(posedge HCLK);
                #1 WFIFO_WFULL = 1'b0;
            end
        join
        chk("wfull_stalls", stall_cnt - s0, 3);
        chk("wfull_cpush", cf_pushes - c0, 4);
        chk("wfull_wpush", wf_pushes - w0, 4);

        // Word read at 0x100, data arrives 5 cycles later.
        snap();
        set_x(0, 32'h0000_0100, 0, 3'd2, 0, 32'h1234_5678, 0, 1);
        fork
            run(1);
            begin
                repeat (5) @(posedge HCLK);
                #1 rq.push_back(32'h1234_5678);
            end
        join
        chk("rd_ren_pulses", ren_cnt - r0, 1);
        chk("rd_cpush", cf_pushes - c0, 1);

        // Write / read / write pipeline with read data already waiting.
        rq.push_back(32'hCAFE_F00D);
        repeat (2) @(posedge HCLK);
        #1;
        snap();
        set_x(0, 32'h0000_0040, 1, 3'd2, 32'hDDDD_DDDD, 0, 0, 1);
        set_x(1, 32'h0000_0044, 0, 3'd2, 32'h0, 32'hCAFE_F00D, 0, 1);
        set_x(2, 32'h0000_0048, 1, 3'd2, 32'hEEEE_EEEE, 0, 0, 1);
        run(3);
        chk("minrd_stalls", stall_cnt - s0, 2);
        chk("minrd_ren", ren_cnt - r0, 1);

`ifdef AHB_MEM_FIFO_ERR_EN
        // Read timeout, then a late word is dropped and the next read gets fresh data.
        snap();
        set_x(0, 32'h0000_0300, 0, 3'd2, 0, 0, 1, 1);
        run(1);
        chk("to_resp_cycles", resp_cnt - e0, 2);
        rq.push_back(32'hDEAD_0001);
        repeat (4) @(posedge HCLK);
        #1;
        chk("to_discard_ren", ren_cnt - r0, 1);
        chk("to_discard_drained", rq.size(), 0);
        rq.push_back(32'hBEEF_0002);
        repeat (2) @(posedge HCLK);
        #1;
        set_x(0, 32'h0000_0304, 0, 3'd2, 0, 32'hBEEF_0002, 0, 1);
        run(1);

        // HSIZE=3 write: two-cycle ERROR, no pushes.
        snap();
        set_x(0, 32'h0000_0008, 1, 3'd3, 32'h9999_9999, 0, 1, 0);
        run(1);
        chk("sz3_resp_cycles", resp_cnt - e0, 2);
        chk("sz3_cpush", cf_pushes - c0, 0);
        chk("sz3_wpush", wf_pushes - w0, 0);
`else
        // HSIZE=3 write is handled as a word access.
        snap();
        set_x(0, 32'h0000_0008, 1, 3'd3, 32'h9999_9999, 0, 0, 1);
        run(1);
        chk("sz3_word_stalls", stall_cnt - s0, 0);
        chk("sz3_word_wpush", wf_pushes - w0, 1);
`endif

        // Reset while a read waits for data.
        cmd_exp.push_back({1'b0, 4'b1111, 26'h200});
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0200; HWRITE = 1'b0; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        repeat (3) @(posedge HCLK);
        #1;
        chk("midrd_stalled", HREADYOUT, 1'b0);
        HRESET = 1'b1;
        #1;
        chk("midrd_rst_hreadyout", HREADYOUT, 1'b1);
        chk("midrd_rst_hresp", HRESP, 1'b0);
        chk("midrd_rst_hrdata", HRDATA, 32'h0);
        chk("midrd_rst_ren", RFIFO_REN, 1'b0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        chk("post_rst_hreadyout", HREADYOUT, 1'b1);
        chk("cmd_sb_empty", cmd_exp.size(), 0);
        chk("wd_sb_empty", wd_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
